des_final_permutation: RTL and testbench
========================================

# des_final_permutation

Output stage of the DES datapath. Takes the 64-bit result of round 16 (L16‖R16), applies the 32-bit half swap and the DES final permutation (IP⁻¹, the exact inverse of the initial permutation), and buffers the resulting ciphertext/plaintext in a 2-entry FIFO. The round core sits upstream. Output is delivered to the system through a valid/ready handshake, 64-bit parallel or byte-serial.

## Interface
- CNT_W, 16: width of the completed-block counter.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  [0:63]  round-16 result; DIN[0:31]=L16, DIN[32:63]=R16; bit 0 is the MSB.
- DIN_VALID  input  1  DIN holds a block.
- DIN_READY  output  1  block can accept; transfer when DIN_VALID&&DIN_READY.
- DOUT  output  [0:63] (parallel) or [0:7] (serial, see Configuration)  result data.
- DOUT_VALID  output  1  DOUT valid.
- DOUT_READY  input  1  downstream accepts; beat transfers when DOUT_VALID&&DOUT_READY.
- BLK_CNT  output  CNT_W  count of fully delivered blocks, wraps modulo 2^CNT_W.

## Operation
- Swap: X = {DIN[32:63], DIN[0:31]} (R16‖L16).
- Final permutation, for row r=0..7 and column c=0..7 (0-based, MSB-first):
  - c even: FP[8r+c] = X[39+4c−r].
  - c odd: FP[8r+c] = X[3+4c−r].
  - Row 0 therefore reads X[39,7,47,15,55,23,63,31].
  - Must satisfy FP(IP(y)) == y for all y.
- Swap and FP are combinational on the input side. The permuted word is written into the FIFO on an accepted transfer.
- FIFO: 2 entries, write pointer, read pointer, occupancy 0..2.
  - DIN_READY = (occupancy < 2); no combinational path from DOUT_READY to DIN_READY.
  - Push and pop in the same cycle leave occupancy unchanged. Pointers wrap 1→0.
- Parallel mode:
  - DOUT = head entry; DOUT_VALID = (occupancy > 0).
  - Pop on a DOUT transfer.
- BLK_CNT increments by 1 when the last beat of a block transfers. 2^CNT_W−1 wraps to 0.
- DOUT and DOUT_VALID hold stable while DOUT_VALID&&!DOUT_READY.

## Timing
- Reset values: DIN_READY=1, DOUT_VALID=0, DOUT=0, BLK_CNT=0; FIFO empty; serial FSM in IDLE with byte index 0.
- RST asserted mid-block discards all buffered data and any partial serial block immediately.
- Latency: a block accepted in cycle N gives DOUT_VALID=1 in cycle N+1 (FIFO empty, parallel).
- Throughput (parallel): one block per cycle, sustained, while DOUT_READY=1.
- Full FIFO with a pop in cycle N gives DIN_READY=1 in cycle N+1.

## Configuration
- DES_FP_BYTE_SERIAL_EN defined:
  - DOUT is [0:7] and each block goes out as 8 beats.
  - FSM states:
    - IDLE: FIFO empty, DOUT_VALID=0. Moves to SHIFT when occupancy > 0.
    - SHIFT: byte index k=0..7, DOUT = head[8k:8k+7] (byte 0 = FP[0:7] first), DOUT_VALID=1.
  - Each transfer advances k.
  - The transfer at k=7 pops the head, increments BLK_CNT, and resets k to 0. The FSM stays in SHIFT if occupancy after the pop is > 0, else returns to IDLE.
  - Throughput: 8 cycles per block.
- DES_FP_BYTE_SERIAL_EN undefined: DOUT is [0:63]; parallel behaviour as above; no FSM.

## Structure
- Shared package des_pkg holds the FP index table as a constant array (64 entries), the block width constant (64) and the half width constant (32).
- The IP table belongs in the same package.
- One sub-module, des_fp_perm: a purely combinational swap plus FP, instantiated once ahead of the FIFO write port.
- FIFO and serializer stay inline in des_final_permutation.

## Test plan
- Known vector: DIN=64'h43423234_0A4CD995, DOUT_READY=1 -> DOUT=64'h85E813540F0AB405 one cycle later; BLK_CNT=1.
- Round trip: random y, feed DIN = swap(IP(y)) for 1000 blocks -> DOUT == y for every block, in order.
- Backpressure: DOUT_READY=0, push 3 blocks -> first two accepted, DIN_READY=0 on the third; DOUT holds block 1 stable. Raise DOUT_READY -> blocks 1, 2, 3 are delivered in order.
- Reset mid-operation: FIFO full, assert RST asynchronously -> DOUT_VALID=0, DIN_READY=1 and BLK_CNT=0 without waiting for a clock edge.
- Serial mode (DES_FP_BYTE_SERIAL_EN): known vector -> bytes 85,E8,13,54,0F,0A,B4,05 over 8 beats. Random DOUT_READY stalls keep each byte stable; BLK_CNT increments only on byte 8.
- Counter wrap with CNT_W=4: deliver 17 blocks -> BLK_CNT reads 1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: block/half widths, IP and IP^-1 bit-index tables (0-based, MSB-first),
// and the serializer state encoding.
package des_pkg;

  localparam int BLK_W  = 64;
  localparam int HALF_W = 32;

  // FP_TBL[i] = index into the swapped word R16||L16 that lands in output bit i
  localparam int FP_TBL [0:63] = '{
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25,
    32,  0, 40,  8, 48, 16, 56, 24
  };

  localparam int IP_TBL [0:63] = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7,
    56, 48, 40, 32, 24, 16,  8,  0,
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6
  };

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/des_fp_perm.sv
// Combinational half swap (L16||R16 -> R16||L16) followed by the DES final permutation IP^-1.
module des_fp_perm
  import des_pkg::*;
(
  input  logic [0:BLK_W-1] din_i,
  output logic [0:BLK_W-1] fp_o
);

  logic [0:BLK_W-1] x;

  assign x = {din_i[HALF_W:BLK_W-1], din_i[0:HALF_W-1]};

  for (genvar i = 0; i < BLK_W; i++) begin : g_fp
    assign fp_o[i] = x[FP_TBL[i]];
  end

endmodule

// File: rtl/des_final_permutation.sv
// DES output stage: swap + IP^-1, 2-entry result FIFO, valid/ready output.
// Define DES_FP_BYTE_SERIAL_EN for an 8-bit DOUT that streams each block as 8 beats.
module des_final_permutation
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [0:63]      DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
`ifdef DES_FP_BYTE_SERIAL_EN
  output logic [0:7]       DOUT,
`else
  output logic [0:63]      DOUT,
`endif
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic [CNT_W-1:0] BLK_CNT
);

  logic [0:BLK_W-1] fp_d;
  logic [0:BLK_W-1] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q;
  logic [0:BLK_W-1] head;
  logic             push, pop, beat;

  des_fp_perm u_perm (
    .din_i (DIN),
    .fp_o  (fp_d)
  );

  assign head      = mem_q[rd_ptr_q];
  assign DIN_READY = (occ_q != 2'd2);
  assign push      = DIN_VALID && DIN_READY;
  assign beat      = DOUT_VALID && DOUT_READY;
  assign BLK_CNT   = cnt_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= fp_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      occ_q <= occ_d;
    end
  end

`ifdef DES_FP_BYTE_SERIAL_EN
  ser_state_e state_q;
  logic [2:0] k_q;

  assign DOUT_VALID = (state_q == S_SHIFT);
  assign DOUT       = DOUT_VALID ? head[{k_q, 3'b000} +: 8] : '0;
  assign pop        = beat && (k_q == 3'd7);

  // k wraps 7->0 on its own, so the last beat needs no explicit clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (occ_q != 2'd0) state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (beat) begin
            k_q <= k_q + 3'd1;
            if ((k_q == 3'd7) && (occ_d == 2'd0)) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign DOUT_VALID = (occ_q != 2'd0);
  assign DOUT       = DOUT_VALID ? head : '0;
  assign pop        = beat;
`endif

endmodule

// File: tb/tb_des_final_permutation.sv
// Directed bench for des_final_permutation; works in parallel and byte-serial builds.
module tb_des_final_permutation;

`ifdef DES_FP_BYTE_SERIAL_EN
  localparam int DW = 8;
`else
  localparam int DW = 64;
`endif
  localparam int BEATS = 64 / DW;
  localparam int CW    = 4;
  localparam int NRT   = 1000;

  // standard DES IP table, 1-based
  localparam int IP1 [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  logic          CLK = 1'b0;
  logic          RST;
  logic [0:63]   DIN;
  logic          DIN_VALID;
  logic          DIN_READY;
  logic [0:DW-1] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY;
  logic [CW-1:0] BLK_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;

  des_final_permutation #(.CNT_W(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .DIN_READY  (DIN_READY),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .BLK_CNT    (BLK_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] swap(input logic [63:0] v);
    return {v[31:0], v[63:32]};
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] y);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = y[64-IP1[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_model(input logic [63:0] d);
    logic [63:0] x, o;
    int src;
    x = swap(d);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        src = (c % 2 == 0) ? (39 + 4*c - r) : (3 + 4*c - r);
        o[63-(8*r+c)] = x[63-src];
      end
    return o;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    bit acc;
    int t;
    DIN       = d;
    DIN_VALID = 1'b1;
    t = 0;
    do begin
      acc = DIN_READY;
      step();
      t++;
    end while (!acc && t < 500);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    DIN_VALID = 1'b0;
  endtask

  task automatic recv(output logic [63:0] blk);
    bit got, held;
    int t;
    logic [DW-1:0] hold;
    blk = '0;
    for (int b = 0; b < BEATS; b++) begin
      got = 1'b0;
      held = 1'b0;
      t = 0;
      while (!got && t < 200) begin
        DOUT_READY = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (DOUT_VALID && DOUT_READY) begin
          blk = (blk << DW) | 64'(DOUT);
          got = 1'b1;
        end else if (DOUT_VALID) begin
          hold = DOUT;
          held = 1'b1;
        end
        step();
        if (held) begin
          chk("dout_hold", {63'd0, DOUT_VALID} | (64'(DOUT) << 1), {63'd0, 1'b1} | (64'(hold) << 1));
          held = 1'b0;
        end
        t++;
      end
      if (!got) chk("recv_timeout", 64'd0, 64'd1);
    end
    DOUT_READY = 1'b0;
  endtask

  logic [63:0] ys [NRT];
  logic [63:0] got, a, b, c, e, v;

  initial begin
    RST = 1'b1; DIN = '0; DIN_VALID = 1'b0; DOUT_READY = 1'b0;
    step(); step();
    chk("rst_din_ready",  64'(DIN_READY),  64'd1);
    chk("rst_dout_valid", 64'(DOUT_VALID), 64'd0);
    chk("rst_dout",       64'(DOUT),       64'd0);
    chk("rst_blk_cnt",    64'(BLK_CNT),    64'd0);
    RST = 1'b0;
    step();

    // known vector
    send(64'h43423234_0A4CD995);
`ifndef DES_FP_BYTE_SERIAL_EN
    chk("latency_valid", 64'(DOUT_VALID), 64'd1);
    chk("latency_dout",  64'(DOUT),       64'h85E813540F0AB405);
`endif
    recv(got);
    chk("known_vec", got, 64'h85E813540F0AB405);
    chk("blk_cnt_1", 64'(BLK_CNT), 64'd1);

    // backpressure: two fill the FIFO, third stalls
    rand_rdy = 1'b1;
    a = 64'h0123456789ABCDEF; b = 64'hFEDCBA9876543210; c = 64'hA5A5F00F3C3C0FF0;
    DOUT_READY = 1'b0;
    send(a); send(b);
    DIN = c; DIN_VALID = 1'b1;
    e = fp_model(a);
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_ready", 64'(DIN_READY),  64'd0);
      chk("bp_valid",      64'(DOUT_VALID), 64'd1);
      chk("bp_head",       64'(DOUT),       64'(e[63 -: DW]));
      step();
    end
    DIN_VALID = 1'b0;
    recv(got);
    chk("bp_blk1", got, fp_model(a));
    chk("ready_after_pop", 64'(DIN_READY), 64'd1);
    send(c);
    recv(got);
    chk("bp_blk2", got, fp_model(b));
    recv(got);
    chk("bp_blk3", got, fp_model(c));
    chk("blk_cnt_4", 64'(BLK_CNT), 64'd4);

    // round trip: DIN = swap(IP(y)) must come back out as y
    for (int i = 0; i < NRT; i++) ys[i] = {$urandom, $urandom};
    fork
      begin
        for (int i = 0; i < NRT; i++) send(swap(ip(ys[i])));
      end
      begin
        logic [63:0] r;
        for (int j = 0; j < NRT; j++) begin
          recv(r);
          chk("roundtrip", r, ys[j]);
        end
      end
    join
    chk("blk_cnt_rt", 64'(BLK_CNT), 64'((4 + NRT) % 16));

    // async reset with a full FIFO
    DOUT_READY = 1'b0;
    send(a); send(b);
    chk("pre_rst_full", 64'(DIN_READY), 64'd0);
    #2 RST = 1'b1;
    #1;
    chk("arst_dout_valid", 64'(DOUT_VALID), 64'd0);
    chk("arst_din_ready",  64'(DIN_READY),  64'd1);
    chk("arst_blk_cnt",    64'(BLK_CNT),    64'd0);
    step();
    RST = 1'b0;
    step();
    chk("post_rst_empty", 64'(DOUT_VALID), 64'd0);

    // counter wrap: 17 blocks on a 4-bit counter
    rand_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      v = {$urandom, $urandom};
      send(v);
      recv(got);
      chk("wrap_data", got, fp_model(v));
    end
    chk("blk_cnt_wrap", 64'(BLK_CNT), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
